// File: rtl/axis_packet_framer_if.sv
// rtl/axis_packet_framer_if.sv - valid-only word input and AXI4-Stream output of axis_packet_framer
interface axis_packet_framer_if #(
   parameter int DATA_W = 32
);
   logic              s_axis_valid;
   logic [DATA_W-1:0] s_axis_data;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tlast;

   // master: the framer itself; slave: the upstream buffer plus downstream consumer
   modport master (
      input  s_axis_valid, s_axis_data, m_axis_tready,
      output m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );
   modport slave (
      output s_axis_valid, s_axis_data, m_axis_tready,
      input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
   );
endinterface

// File: rtl/axis_packet_framer.sv
// rtl/axis_packet_framer.sv - frames a stall-free word stream into AXI4-Stream packets through a FWFT FIFO
module axis_packet_framer #(
   parameter int DATA_W  = 32,
   parameter int PKT_LEN = 64,
   parameter int DEPTH   = 128,
   parameter int CNT_W   = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   axis_packet_framer_if.master    axis,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_overflow,
   output logic [CNT_W-1:0]        o_pkt_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IW-1:0] IN_LAST = IW'(PKT_LEN - 1);
   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

   logic [DATA_W:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [IW-1:0]   in_cnt;
   logic [AW:0]     mem_cnt;
   logic            in_last;
   logic            pop;
   logic            push;
   logic            load;
   logic            mem_empty;
   logic            bypass;

   // The output register counts toward o_level, so the RAM holds o_level - tvalid words.
   always_comb begin
      in_last   = (in_cnt == IN_LAST);
      pop       = axis.m_axis_tvalid && axis.m_axis_tready;
      push      = axis.s_axis_valid && ((o_level < FULL) || pop);
      load      = !axis.m_axis_tvalid || pop;
      mem_cnt   = o_level - {{AW{1'b0}}, axis.m_axis_tvalid};
      mem_empty = (mem_cnt == '0);
      bypass    = push && load && mem_empty;
   end

   always_ff @(posedge i_clk) begin
      if (push && !bypass)
         mem[wr_ptr] <= {in_last, axis.s_axis_data};
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tlast  <= 1'b0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         in_cnt             <= '0;
         o_level            <= '0;
         o_overflow         <= 1'b0;
         o_pkt_count        <= '0;
      end else begin
         // Framing follows every upstream beat, dropped or not.
         if (axis.s_axis_valid)
            in_cnt <= in_last ? '0 : in_cnt + 1'b1;

         if (push && !bypass)
            wr_ptr <= wr_ptr + 1'b1;

         if (load) begin
            if (!mem_empty) begin
               {axis.m_axis_tlast, axis.m_axis_tdata} <= mem[rd_ptr];
               rd_ptr             <= rd_ptr + 1'b1;
               axis.m_axis_tvalid <= 1'b1;
            end else if (push) begin
               axis.m_axis_tlast  <= in_last;
               axis.m_axis_tdata  <= axis.s_axis_data;
               axis.m_axis_tvalid <= 1'b1;
            end else begin
               axis.m_axis_tvalid <= 1'b0;
            end
         end

         if (push && !pop)
            o_level <= o_level + 1'b1;
         else if (pop && !push)
            o_level <= o_level - 1'b1;

         if (axis.s_axis_valid && !push)
            o_overflow <= 1'b1;

         if (pop && axis.m_axis_tlast)
            o_pkt_count <= o_pkt_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_axis_packet_framer.sv
// tb/tb_axis_packet_framer.sv - scoreboard bench for axis_packet_framer against a queue-based packet model
module tb_axis_packet_framer;
   localparam int DATA_W  = 32;
   localparam int PKT_LEN = 64;
   localparam int DEPTH   = 128;
   localparam int CNT_W   = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic [CNT_W-1:0]       pkt_count;

   axis_packet_framer_if #(.DATA_W(DATA_W)) bus ();

   axis_packet_framer #(
      .DATA_W (DATA_W),
      .PKT_LEN(PKT_LEN),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .axis       (bus),
      .o_level    (level),
      .o_overflow (overflow),
      .o_pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // model_q: words the framer should hold; exp_q: scoreboard of accepted words in order
   logic [DATA_W:0]  model_q[$];
   logic [DATA_W:0]  exp_q[$];
   int               m_in_cnt = 0;
   logic             m_ovf = 1'b0;
   logic [CNT_W-1:0] m_pkt = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_cycle(input logic v, input logic [DATA_W-1:0] d, input logic r);
      logic pop_m, push_m, last_m;
      pop_m  = (model_q.size() > 0) && r;
      push_m = v && ((model_q.size() < DEPTH) || pop_m);
      last_m = (m_in_cnt == PKT_LEN - 1);
      if (pop_m) begin
         if (model_q[0][DATA_W]) m_pkt = m_pkt + 1'b1;
         void'(model_q.pop_front());
      end
      if (push_m) begin
         model_q.push_back({last_m, d});
         exp_q.push_back({last_m, d});
      end else if (v) begin
         m_ovf = 1'b1;
      end
      if (v) m_in_cnt = (m_in_cnt + 1) % PKT_LEN;
   endtask

   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
      @(posedge clk);
      #1;
      chk("level", level, model_q.size());
      chk("tvalid", bus.m_axis_tvalid, model_q.size() != 0);
      chk("overflow", overflow, m_ovf);
      chk("pkt_count", pkt_count, m_pkt);
      bus.s_axis_valid  = v;
      bus.s_axis_data   = d;
      bus.m_axis_tready = r;
      model_cycle(v, d, r);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && model_q.size() > 0; i++) step(1'b0, '0, 1'b1);
      if (model_q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: got %0d words left expected 0", model_q.size());
      end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_tvalid", bus.m_axis_tvalid, 0);
      chk("rst_tdata", bus.m_axis_tdata, 0);
      chk("rst_tlast", bus.m_axis_tlast, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_pkt_count", pkt_count, 0);
      model_q.delete();
      exp_q.delete();
      m_in_cnt = 0;
      m_ovf    = 1'b0;
      m_pkt    = '0;
      bus.s_axis_valid  = 1'b0;
      bus.s_axis_data   = '0;
      bus.m_axis_tready = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every output handshake and checks stability under stall.
   initial begin
      logic            stall_prev;
      logic [DATA_W:0] hold;
      logic [DATA_W:0] e;
      stall_prev = 1'b0;
      hold       = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_tvalid", bus.m_axis_tvalid, 1);
               chk("hold_word", {bus.m_axis_tlast, bus.m_axis_tdata}, hold);
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL out_word: got %0h expected no word",
                           {bus.m_axis_tlast, bus.m_axis_tdata});
               end else begin
                  e = exp_q.pop_front();
                  chk("out_word", {bus.m_axis_tlast, bus.m_axis_tdata}, e);
               end
            end
            stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
            hold       = {bus.m_axis_tlast, bus.m_axis_tdata};
         end
      end
   end

   initial begin
      int rprob;
      bus.s_axis_valid  = 1'b0;
      bus.s_axis_data   = '0;
      bus.m_axis_tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_tvalid", bus.m_axis_tvalid, 0);
      chk("init_tdata", bus.m_axis_tdata, 0);
      chk("init_level", level, 0);
      chk("init_pkt_count", pkt_count, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      for (int i = 0; i < 64; i++) step(1'b1, DATA_W'(i), 1'b1);
      drain();

      for (int i = 0; i < 64; i++) step(1'b1, DATA_W'(100 + i), 1'b0);
      drain();

      for (int i = 0; i < 128; i++) step(1'b1, DATA_W'(200 + i), (i % 2) == 0);
      drain();

      for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(500 + i), 1'b1);
      do_reset();
      for (int i = 0; i < 64; i++) step(1'b1, DATA_W'(600 + i), 1'b1);
      drain();

      for (int i = 0; i < 128; i++) step(1'b1, DATA_W'(700 + i), 1'b0);
      step(1'b1, DATA_W'(900), 1'b1);
      step(1'b0, '0, 1'b0);
      drain();

      do_reset();
      for (int i = 0; i < 130; i++) step(1'b1, DATA_W'(1000 + i), 1'b0);
      drain();

      rprob = 100;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            case ($urandom_range(0, 3))
               0: rprob = 15;
               1: rprob = 50;
               2: rprob = 90;
               default: rprob = 100;
            endcase
         end
         step($urandom_range(0, 99) < 80, $urandom, $urandom_range(0, 99) < rprob);
      end
      drain();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
